// File: rtl/watchdog_pkg.sv
// Shared watchdog definitions: QF format constants, period meter FSM states
// and the saturation limit of the period counter.
package watchdog_pkg;

  localparam int F = 16;
  localparam logic [31:0] TWO_QF = 32'h0002_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_REQ,
    S_WAIT
  } pm_state_t;

  // Largest value a counter of the given width can hold.
  function automatic int unsigned cntMax(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/evt_sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a one-cycle
// rising-edge pulse on the synchronised signal.
module evt_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/period_meter.sv
// Heartbeat period meter: measures clk cycles between event edges, sends the
// QF period to the reciprocal unit and reports the returned rate.
// Optional build macro PERIOD_AVG_EN sends the average of every 4 periods.
module period_meter
  import watchdog_pkg::*;
#(
  parameter int W           = 32,
  parameter int F           = watchdog_pkg::F,
  parameter int TICK_SHIFT  = 4,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         evt_in,
  output logic         recip_start,
  output logic [W-1:0] recip_x,
  input  logic         recip_done,
  input  logic [W-1:0] recip_inv,
  input  logic         recip_invalid,
  output logic [W-1:0] rate_out,
  output logic         rate_valid,
  output logic         rate_zero,
  output logic         sat,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = W - 1 - F + TICK_SHIFT;
  localparam int SH = F - TICK_SHIFT;
  localparam logic [CW-1:0] CNT_MAX = CW'(cntMax(CW));
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT_CYC);

  pm_state_t      r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_sat;
  logic [W-1:0]   r_x;
  logic           r_start;
  logic [W-1:0]   r_rate;
  logic           r_valid;
  logic           r_zero;
  logic           r_tag;
  logic [W-1:0]   r_pend;
  logic           r_pendFull;
  logic           r_ovr;
  logic           r_busy;

  logic           w_edge;
  logic           w_active;
  logic           w_timeout;
  logic [W-1:0]   w_xNew;
  logic           w_sendEdge;
  logic [W-1:0]   w_sendX;
  logic           w_capture;

  evt_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (evt_in),
    .o_rise  (w_edge)
  );

  assign w_active  = (r_state == S_MEAS) || (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_timeout = (r_state == S_MEAS) && enable && !w_edge && (r_cnt == TO_VAL);
  assign w_xNew    = W'(r_cnt) << SH;

  // The counter restarts at 1 so the value seen on the next edge equals the edge spacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_cnt <= '0;
      else if (w_edge)
        r_cnt <= CW'(1);
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
      if (w_active && (r_cnt == CNT_MAX))
        r_sat <= 1'b1;
    end
  end

`ifdef PERIOD_AVG_EN
  logic [W+1:0] r_acc;
  logic [1:0]   r_accCnt;
  logic [W+1:0] w_sum;

  assign w_sum      = r_acc + (W+2)'(w_xNew);
  assign w_sendEdge = w_edge && (r_accCnt == 2'd3);
  assign w_sendX    = w_sum[W+1:2];

  // Only the fourth edge of a group produces a period; a timeout drops the partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_accCnt <= '0;
    end else if ((r_state == S_IDLE) || (r_state == S_ARM) || w_timeout) begin
      r_acc    <= '0;
      r_accCnt <= '0;
    end else if (w_edge) begin
      r_acc    <= (r_accCnt == 2'd3) ? '0 : w_sum;
      r_accCnt <= r_accCnt + 2'd1;
    end
  end
`else
  assign w_sendEdge = w_edge;
  assign w_sendX    = w_xNew;
`endif

  assign w_capture = w_sendEdge &&
                     ((r_state == S_REQ) || ((r_state == S_WAIT) && !recip_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_start    <= 1'b0;
      r_rate     <= '0;
      r_valid    <= 1'b0;
      r_zero     <= 1'b0;
      r_tag      <= 1'b0;
      r_pend     <= '0;
      r_pendFull <= 1'b0;
      r_ovr      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (enable) r_state <= S_ARM;
        S_ARM: begin
          if (!enable)     r_state <= S_IDLE;
          else if (w_edge) r_state <= S_MEAS;
        end
        S_MEAS: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_sendEdge) begin
            r_x     <= w_sendX;
            r_tag   <= 1'b0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_REQ;
          end else if (w_timeout) begin
            r_x     <= '0;
            r_tag   <= 1'b1;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          // An edge arriving with the result is sent straight away, behind any pending period.
          if (recip_done) begin
            r_rate  <= recip_invalid ? '0 : recip_inv;
            r_valid <= 1'b1;
            r_zero  <= r_tag;
            if (!enable || r_tag) begin
              r_state    <= enable ? S_ARM : S_IDLE;
              r_busy     <= 1'b0;
              r_pendFull <= 1'b0;
            end else if (r_pendFull) begin
              r_x        <= r_pend;
              r_start    <= 1'b1;
              r_state    <= S_REQ;
              r_pendFull <= w_sendEdge;
              if (w_sendEdge) r_pend <= w_sendX;
            end else if (w_sendEdge) begin
              r_x     <= w_sendX;
              r_start <= 1'b1;
              r_state <= S_REQ;
            end else begin
              r_state <= S_MEAS;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_capture) begin
        if (r_pendFull) r_ovr <= 1'b1;
        r_pend     <= w_sendX;
        r_pendFull <= 1'b1;
      end
    end
  end

  assign recip_start = r_start;
  assign recip_x     = r_x;
  assign rate_out    = r_rate;
  assign rate_valid  = r_valid;
  assign rate_zero   = r_zero;
  assign sat         = r_sat;
  assign overrun     = r_ovr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter with a behavioural reciprocal responder;
// expected periods and rates are hand-computed constants queued with stimulus.
module tb_period_meter;
  import watchdog_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        evt_in;
  logic        recip_start;
  logic [31:0] recip_x;
  logic        recip_done;
  logic [31:0] recip_inv;
  logic        recip_invalid;
  logic [31:0] rate_out;
  logic        rate_valid;
  logic        rate_zero;
  logic        sat;
  logic        overrun;
  logic        busy;

  typedef struct packed {
    logic [31:0] rate;
    logic        zero;
  } rateExp_t;

  logic [31:0] xq[$];
  rateExp_t    rq[$];
  int          nVec = 0;
  int          nMis = 0;
  int          respDelay = 3;

  period_meter #(
    .W(32), .F(16), .TICK_SHIFT(4), .TIMEOUT_CYC(1000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .evt_in        (evt_in),
    .recip_start   (recip_start),
    .recip_x       (recip_x),
    .recip_done    (recip_done),
    .recip_inv     (recip_inv),
    .recip_invalid (recip_invalid),
    .rate_out      (rate_out),
    .rate_valid    (rate_valid),
    .rate_zero     (rate_zero),
    .sat           (sat),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Raise evt_in now and return gap cycles later, just after a rising clk edge.
  task automatic applyStimulus(input int gap);
    evt_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 evt_in = 1'b0;
    repeat (gap - 4) @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] x, input logic [31:0] rate, input logic zero);
    xq.push_back(x);
    rq.push_back('{rate: rate, zero: zero});
  endtask

  // Reciprocal model: 1/x in QF16 is 2^32/x; non-positive x is flagged invalid.
  always begin
    logic [31:0] xCap;
    @(negedge clk);
    if (rst_n && recip_start) begin
      xCap = recip_x;
      repeat (respDelay) @(posedge clk);
      #1;
      recip_done = 1'b1;
      if (xCap == 32'd0 || xCap[31]) begin
        recip_invalid = 1'b1;
        recip_inv     = 32'hDEAD_BEEF;
      end else begin
        recip_invalid = 1'b0;
        recip_inv     = 32'(64'h1_0000_0000 / {32'd0, xCap});
      end
      @(posedge clk);
      #1;
      recip_done    = 1'b0;
      recip_invalid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (recip_start) begin
        if (xq.size() == 0) checkOutput("unexpected recip_start", 64'(recip_start), 64'd0);
        else                checkOutput("recip_x", 64'(recip_x), 64'(xq.pop_front()));
      end
      if (rate_valid) begin
        if (rq.size() == 0) begin
          checkOutput("unexpected rate_valid", 64'(rate_valid), 64'd0);
        end else begin
          rateExp_t e;
          e = rq.pop_front();
          checkOutput("rate_out", 64'(rate_out), 64'(e.rate));
          checkOutput("rate_zero", 64'(rate_zero), 64'(e.zero));
        end
      end
    end
  end

  task automatic checkDrained(input string name);
    checkOutput({name, " recip_x queue left"}, 64'(xq.size()), 64'd0);
    checkOutput({name, " rate queue left"}, 64'(rq.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; evt_in = 1'b0;
    recip_done = 1'b0; recip_inv = '0; recip_invalid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset outputs",
                {recip_start, recip_x, rate_valid, rate_zero, sat, overrun, busy}, 64'd0);
    checkOutput("reset rate_out", 64'(rate_out), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1 enable = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Edges every 32 clk give 2.0 / 0.5, then silence times out to rate 0.
    respDelay = 3;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) pushExp(TWO_QF, 32'h0000_8000, 1'b0);
      applyStimulus(32);
    end
    pushExp(32'd0, 32'd0, 1'b1);
    repeat (1100) @(posedge clk);
    @(negedge clk);
    checkOutput("state after timeout", 64'(dut.r_state), 64'(S_ARM));
    checkOutput("overrun before pending test", 64'(overrun), 64'd0);
    checkDrained("periodic+timeout");
    @(posedge clk); #1;

    // Edge coincident with count 1000 still sends the real period.
    pushExp(32'h003E_8000, 32'h0000_0418, 1'b0);
    pushExp(32'd0, 32'd0, 1'b1);
    applyStimulus(1000);
    applyStimulus(1100);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkDrained("coincident edge");
    @(posedge clk); #1;

    // Edges every 16 clk against a slow reciprocal: pending path and overrun.
    respDelay = 40;
    for (int i = 0; i < 3; i++) pushExp(32'h0001_0000, 32'h0001_0000, 1'b0);
    pushExp(32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(16);
    repeat (1300) @(posedge clk);
    @(negedge clk);
    checkOutput("overrun sticky", 64'(overrun), 64'd1);
    checkOutput("sat", 64'(sat), 64'd0);
    checkDrained("pending");
    @(posedge clk); #1;

    // enable drops mid-wait: the result still arrives once, then idle.
    respDelay = 20;
    pushExp(TWO_QF, 32'h0000_8000, 1'b0);
    applyStimulus(32);
    evt_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 evt_in = 1'b0;
    repeat (8) @(posedge clk);
    #1 enable = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("busy after disable", 64'(busy), 64'd0);
    checkOutput("state after disable", 64'(dut.r_state), 64'(S_IDLE));
    @(posedge clk); #1;
    applyStimulus(40);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkDrained("disable");
    @(posedge clk); #1;

    // Reset in the middle of a wait; the late recip_done must be ignored.
    enable = 1'b1;
    repeat (3) @(posedge clk); #1;
    xq.push_back(TWO_QF);
    applyStimulus(32);
    evt_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 evt_in = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("outputs in reset",
                {recip_start, recip_x, rate_valid, rate_zero, sat, overrun, busy}, 64'd0);
    checkOutput("rate_out in reset", 64'(rate_out), 64'd0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("rate_out after late done", 64'(rate_out), 64'd0);
    checkDrained("reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
